comb_channel_selector: RTL

Upstream stage of the combination measurement. It takes the raw time-tag stream, which carries WORDSIZE lanes per beat, and remaps each tag's raw channel index through a runtime-programmable LUT to a compact combination channel index (0..CHANNELS-1) plus a valid bit. Tags whose LUT entry is invalid are dropped and counted. The LUT is programmed and read back over a simple request/ack port, which the combination register block drives from wishbone address 0x08.

---
 rtl/comb_channel_selector.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/comb_channel_selector.sv
// Remaps raw time-tag channels to compact combination channels through a
// programmable LUT; lanes with an invalid mapping are dropped and counted.
module comb_channel_selector #(
    parameter int CHANNELS  = 16,
    parameter int LUT_DEPTH = 64,
    parameter int WORDSIZE  = 4,
    parameter int TIME_W    = 64,
    localparam int CH_W     = $clog2(CHANNELS),
    localparam int RAW_W    = $clog2(LUT_DEPTH),
    localparam int ENT_W    = CH_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic [WORDSIZE-1:0]        s_lane_vd,
    input  logic [WORDSIZE*RAW_W-1:0]  s_channel,
    input  logic [WORDSIZE*TIME_W-1:0] s_time,
    output logic                       m_valid,
    output logic [WORDSIZE-1:0]        m_lane_vd,
    output logic [WORDSIZE*CH_W-1:0]   m_channel,
    output logic [WORDSIZE*TIME_W-1:0] m_time,
    input  logic [1:0]                 lut_WrRd,
    input  logic [13:0]                lut_addr,
    input  logic [ENT_W-1:0]           lut_dat_i,
    output logic [ENT_W-1:0]           lut_dat_o,
    output logic                       lut_ack,
    output logic                       ready_o,
    output logic [31:0]                drop_cnt
);
    localparam int DROP_W = $clog2(WORDSIZE + 1);

    typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, ACK} state_t;

    state_t                     state_q, state_d;
    logic [RAW_W-1:0]           clr_cnt_q, clr_cnt_d;
    logic                       ready_q, ready_d;
    logic                       lut_ack_q, lut_ack_d;
    logic [ENT_W-1:0]           lut_dat_q, lut_dat_d;

    logic [ENT_W-1:0]           lut_mem [LUT_DEPTH];
    logic                       lut_we;
    logic [RAW_W-1:0]           lut_waddr;
    logic [ENT_W-1:0]           lut_wdata;
    logic                       addr_ok;
    logic [RAW_W-1:0]           req_idx;

    logic                       vld_p1_q, vld_p1_d;
    logic [WORDSIZE-1:0]        lane_vd_p1_q, lane_vd_p1_d;
    logic [WORDSIZE*RAW_W-1:0]  ch_p1_q, ch_p1_d;
    logic [WORDSIZE*TIME_W-1:0] time_p1_q, time_p1_d;

    logic                       vld_p2_q, vld_p2_d;
    logic [WORDSIZE-1:0]        lane_vd_p2_q, lane_vd_p2_d;
    logic [WORDSIZE*CH_W-1:0]   chan_p2_q, chan_p2_d;
    logic [WORDSIZE*TIME_W-1:0] time_p2_q, time_p2_d;
    logic [31:0]                drop_cnt_q, drop_cnt_d;
    logic [DROP_W-1:0]          drops;
    logic [ENT_W-1:0]           ent;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [DROP_W-1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    assign req_idx = lut_addr[RAW_W-1:0];
    assign addr_ok = lut_addr < 14'(LUT_DEPTH);

    // LUT access controller: CLEAR wipes every entry once after reset
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        lut_ack_d = 1'b0;
        lut_dat_d = lut_dat_q;
        lut_we    = 1'b0;
        lut_waddr = '0;
        lut_wdata = '0;
        case (state_q)
            CLEAR: begin
                lut_we    = 1'b1;
                lut_waddr = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + RAW_W'(1);
                if (clr_cnt_q == RAW_W'(LUT_DEPTH - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (lut_WrRd == 2'b10 || lut_WrRd == 2'b01) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d   = ACK;
                lut_ack_d = 1'b1;
                if (lut_WrRd == 2'b10) begin
                    lut_we    = addr_ok;
                    lut_waddr = req_idx;
                    lut_wdata = lut_dat_i;
                end else if (lut_WrRd == 2'b01) begin
                    lut_dat_d = addr_ok ? lut_mem[req_idx] : '0;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Stage 1: register the incoming beat; lane valids only mean something with s_valid
    always_comb begin
        vld_p1_d     = s_valid;
        lane_vd_p1_d = s_valid ? s_lane_vd : '0;
        ch_p1_d      = s_channel;
        time_p1_d    = s_time;
    end

    // Stage 2: lookup reads the array before this edge's write, so a same-cycle write is not seen
    always_comb begin
        vld_p2_d     = vld_p1_q;
        time_p2_d    = time_p1_q;
        lane_vd_p2_d = '0;
        chan_p2_d    = '0;
        drops        = '0;
        ent          = '0;
        for (int i = 0; i < WORDSIZE; i++) begin
            ent = lut_mem[ch_p1_q[i*RAW_W +: RAW_W]];
            if (lane_vd_p1_q[i] && ready_q) begin
                if (ent[CH_W]) begin
                    lane_vd_p2_d[i]              = 1'b1;
                    chan_p2_d[i*CH_W +: CH_W]    = ent[CH_W-1:0];
                end else begin
                    drops = drops + DROP_W'(1);
                end
            end
        end
        drop_cnt_d = sat_add32(drop_cnt_q, drops);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            ready_q      <= 1'b0;
            lut_ack_q    <= 1'b0;
            lut_dat_q    <= '0;
            vld_p1_q     <= 1'b0;
            lane_vd_p1_q <= '0;
            ch_p1_q      <= '0;
            time_p1_q    <= '0;
            vld_p2_q     <= 1'b0;
            lane_vd_p2_q <= '0;
            chan_p2_q    <= '0;
            time_p2_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            ready_q      <= ready_d;
            lut_ack_q    <= lut_ack_d;
            lut_dat_q    <= lut_dat_d;
            vld_p1_q     <= vld_p1_d;
            lane_vd_p1_q <= lane_vd_p1_d;
            ch_p1_q      <= ch_p1_d;
            time_p1_q    <= time_p1_d;
            vld_p2_q     <= vld_p2_d;
            lane_vd_p2_q <= lane_vd_p2_d;
            chan_p2_q    <= chan_p2_d;
            time_p2_q    <= time_p2_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lut_we && !rst) begin
            lut_mem[lut_waddr] <= lut_wdata;
        end
    end

    assign m_valid   = vld_p2_q;
    assign m_lane_vd = lane_vd_p2_q;
    assign m_channel = chan_p2_q;
    assign m_time    = time_p2_q;
    assign lut_dat_o = lut_dat_q;
    assign lut_ack   = lut_ack_q;
    assign ready_o   = ready_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
